// File: rtl/uart_arb_pkg.sv
// Shared definitions for the MCU-link UART transmit arbiter and the frame-reply modules.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    localparam int unsigned DEF_IDLE_GAP    = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 50_000_000;

    // Frame delimiters used by every reply source on the MCU link.
    localparam logic [7:0] FRAME_SOF = 8'h7E;
    localparam logic [7:0] FRAME_EOF = 8'h7F;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin one-hot selector: first set req bit searching upward from last+1, wrapping.
// Latency: combinational.
// Backpressure: none; onehot is all zero when no request is set.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]         onehot
);
    localparam int LW = $clog2(N_REQ);

    logic [LW-1:0] idx;
    logic          found;

    // Walk the requesters in priority order starting just after the last owner.
    always_comb begin
        onehot = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = LW'((int'(last) + k) % N_REQ);
            if (!found && req[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ frame sources, round-robin, grant held per frame.
// Latency: grant 1 cycle after req_run; data/start forwarded 1 cycle; req_tx_idle combinational.
// Backpressure: non-owners see tx_idle=1 and their starts are dropped; UART_TX_ARB_TIMEOUT_EN adds a stalled-owner timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          N_REQ       = 4,
    parameter int unsigned IDLE_GAP    = DEF_IDLE_GAP,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_run,
    input  logic [8*N_REQ-1:0] req_tx_data,
    input  logic [N_REQ-1:0]   req_start_tx,
    output logic [N_REQ-1:0]   req_tx_idle,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    input  logic               uart_tx_idle,
    output logic [7:0]         uart_tx_data,
    output logic               uart_start_tx,
    output logic               timeout_err
);
    localparam int LW = $clog2(N_REQ);
    localparam int GW = $clog2(IDLE_GAP + 1);

    arb_state_t        state, state_nxt;
    logic [N_REQ-1:0]  grant_nxt, pick, avail;
    logic [LW-1:0]     last_grant, last_nxt, pick_idx;
    logic [7:0]        data_nxt, owner_data;
    logic              start_nxt, owner_run, owner_start;
    logic [GW-1:0]     gap_cnt, gap_nxt;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [31:0]       tmo_cnt, tmo_cnt_nxt;
    logic [N_REQ-1:0]  mask, mask_nxt;
    logic              tmo_err_nxt;

    // A requester that timed out stays excluded until it drops its run flag.
    assign avail = req_run & ~mask;
`else
    assign avail = req_run;
    // Nothing can force a release in this build; the limit is referenced so both builds share one parameter list.
    assign timeout_err = 1'b0 & (TIMEOUT_CYC == 0);
`endif

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (avail),
        .last   (last_grant),
        .onehot (pick)
    );

    // last_grant always names the current owner while in GRANT.
    assign owner_run   = req_run[last_grant];
    assign owner_start = req_start_tx[last_grant];
    assign owner_data  = req_tx_data[{last_grant, 3'b000} +: 8];

    // Only the owner sees the real transmitter state, so others never see a false tx-done edge.
    assign req_tx_idle = (state == ST_GRANT) ? (~grant | {N_REQ{uart_tx_idle}}) : '1;
    assign busy        = (state != ST_IDLE);

    // Convert the one-hot pick into an index for last_grant.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_idx = LW'(i);
        end
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        last_nxt    = last_grant;
        data_nxt    = uart_tx_data;
        start_nxt   = 1'b0;
        gap_nxt     = gap_cnt;
`ifdef UART_TX_ARB_TIMEOUT_EN
        tmo_cnt_nxt = tmo_cnt;
        mask_nxt    = mask & req_run;
        tmo_err_nxt = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (|avail) begin
                    grant_nxt   = pick;
                    last_nxt    = pick_idx;
                    state_nxt   = ST_GRANT;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    tmo_cnt_nxt = '0;
`endif
                end
            end
            ST_GRANT: begin
                // Forwarded even on the cycle run falls, so a last-byte start is never lost.
                data_nxt  = owner_data;
                start_nxt = owner_start;
                if (!owner_run) begin
                    state_nxt = ST_DRAIN;
                    grant_nxt = '0;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (owner_start) begin
                    tmo_cnt_nxt = '0;
                end else if (tmo_cnt + 32'd1 >= TIMEOUT_CYC) begin
                    tmo_err_nxt          = 1'b1;
                    mask_nxt[last_grant] = 1'b1;
                    state_nxt            = ST_DRAIN;
                    grant_nxt            = '0;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 32'd1;
                end
`endif
            end
            ST_DRAIN: begin
                // A start still in flight means the UART has not yet dropped idle for that byte.
                if (uart_tx_idle && !uart_start_tx) begin
                    state_nxt = ST_GAP;
                    gap_nxt   = '0;
                end
            end
            ST_GAP: begin
                if (32'(gap_cnt) + 32'd1 >= IDLE_GAP) begin
                    state_nxt = ST_IDLE;
                end
                if (gap_cnt != GW'(IDLE_GAP)) begin
                    gap_nxt = gap_cnt + GW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; synchronous reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            grant         <= '0;
            last_grant    <= LW'(N_REQ - 1);
            uart_tx_data  <= '0;
            uart_start_tx <= 1'b0;
            gap_cnt       <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmo_cnt       <= '0;
            mask          <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            grant         <= grant_nxt;
            last_grant    <= last_nxt;
            uart_tx_data  <= data_nxt;
            uart_start_tx <= start_nxt;
            gap_cnt       <= gap_nxt;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmo_cnt       <= tmo_cnt_nxt;
            mask          <= mask_nxt;
            timeout_err   <= tmo_err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single frame, round-robin, isolation, drain, timeout, mid-frame reset.
// Latency: inputs driven #1 after the rising edge, outputs sampled at the same point.
// Backpressure: the UART is emulated by toggling uart_tx_idle by hand around each forwarded start.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_run;
    logic [8*N-1:0] req_tx_data;
    logic [N-1:0]   req_start_tx;
    logic [N-1:0]   req_tx_idle;
    logic [N-1:0]   grant;
    logic           busy;
    logic           uart_tx_idle;
    logic [7:0]     uart_tx_data;
    logic           uart_start_tx;
    logic           timeout_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_tx_arbiter #(.N_REQ(N), .IDLE_GAP(16), .TIMEOUT_CYC(100)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_run       (req_run),
        .req_tx_data   (req_tx_data),
        .req_start_tx  (req_start_tx),
        .req_tx_idle   (req_tx_idle),
        .grant         (grant),
        .busy          (busy),
        .uart_tx_idle  (uart_tx_idle),
        .uart_tx_data  (uart_tx_data),
        .uart_start_tx (uart_start_tx),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL %s_wait_idle: busy=%b after %0d cycles, want 0", tag, busy, n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_run = '0; req_tx_data = '0; req_start_tx = '0; uart_tx_idle = 1'b1;
        tick(); tick();
        total_cnt++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (uart_tx_data !== 8'h00 || uart_start_tx !== 1'b0) $display("FAIL reset_uart: data %h start %b want 00/0", uart_tx_data, uart_start_tx); else pass_cnt++;
        total_cnt++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout_err); else pass_cnt++;
        total_cnt++; if (req_tx_idle !== 4'b1111) $display("FAIL reset_req_idle: got %b want 1111", req_tx_idle); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        logic [7:0] d;
        req_run = 4'b0001;
        tick();
        total_cnt++; if (grant !== 4'b0001 || busy !== 1'b1) $display("FAIL frame_grant: grant %b busy %b want 0001/1", grant, busy); else pass_cnt++;
        for (int b = 0; b < 30; b++) begin
            d = 8'(8'h20 + b * 3);
            req_tx_data[7:0] = d;
            req_start_tx = 4'b0001;
            tick();
            req_start_tx = '0;
            total_cnt++;
            if (uart_start_tx !== 1'b1 || uart_tx_data !== d) $display("FAIL frame_byte%0d: start %b data %h want 1/%h", b, uart_start_tx, uart_tx_data, d);
            else pass_cnt++;
            if (b == 0) begin
                total_cnt++; if (req_tx_idle !== 4'b1111) $display("FAIL frame_idle_hi: got %b want 1111", req_tx_idle); else pass_cnt++;
            end
            uart_tx_idle = 1'b0;
            #1;
            if (b == 0) begin
                total_cnt++; if (req_tx_idle !== 4'b1110) $display("FAIL frame_idle_lo: got %b want 1110", req_tx_idle); else pass_cnt++;
            end
            tick();
            if (b == 0) begin
                total_cnt++; if (uart_start_tx !== 1'b0) $display("FAIL frame_start_pulse: got %b want 0", uart_start_tx); else pass_cnt++;
            end
            tick();
            uart_tx_idle = 1'b1;
            tick();
        end
        req_run = 4'b0000;
        tick();
        total_cnt++; if (grant !== 4'b0000 || busy !== 1'b1) $display("FAIL frame_release: grant %b busy %b want 0000/1", grant, busy); else pass_cnt++;
        for (int i = 2; i <= 17; i++) begin
            tick();
            if (i == 5) req_run = 4'b0010;
        end
        total_cnt++; if (busy !== 1'b1) $display("FAIL frame_gap_busy: got %b want 1", busy); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0 || grant !== 4'b0000) $display("FAIL frame_gap_end: busy %b grant %b want 0/0000", busy, grant); else pass_cnt++;
        tick();
        total_cnt++; if (grant !== 4'b0010) $display("FAIL frame_held_req: got %b want 0010", grant); else pass_cnt++;
        req_run = '0;
        tick();
        wait_idle("frame");
    endtask

    task automatic test_round_robin();
        req_run = 4'b0001;
        tick();
        total_cnt++; if (grant !== 4'b0001) $display("FAIL rr_setup: got %b want 0001", grant); else pass_cnt++;
        req_run = '0; tick(); wait_idle("rr_a");
        req_run = 4'b1010;
        tick();
        total_cnt++; if (grant !== 4'b0010) $display("FAIL rr_first: got %b want 0010", grant); else pass_cnt++;
        req_run = 4'b1000; tick(); wait_idle("rr_b"); tick();
        total_cnt++; if (grant !== 4'b1000) $display("FAIL rr_second: got %b want 1000", grant); else pass_cnt++;
        req_run = 4'b0101; tick(); wait_idle("rr_c"); tick();
        total_cnt++; if (grant !== 4'b0001) $display("FAIL rr_wrap: got %b want 0001", grant); else pass_cnt++;
        req_run = 4'b0100; tick(); req_run = 4'b0101; wait_idle("rr_d"); tick();
        total_cnt++; if (grant !== 4'b0100) $display("FAIL rr_fair: got %b want 0100", grant); else pass_cnt++;
        req_run = 4'b0001; tick(); wait_idle("rr_e"); tick();
        total_cnt++; if (grant !== 4'b0001) $display("FAIL rr_return: got %b want 0001", grant); else pass_cnt++;
        req_run = '0; tick(); wait_idle("rr_f");
    endtask

    task automatic test_nonowner_start();
        logic seen;
        req_run = 4'b0010;
        req_tx_data[15:8] = 8'h11;
        tick();
        total_cnt++; if (grant !== 4'b0010) $display("FAIL iso_grant: got %b want 0010", grant); else pass_cnt++;
        req_tx_data[23:16] = 8'hEE;
        req_start_tx = 4'b0100;
        tick();
        req_start_tx = '0;
        total_cnt++; if (uart_start_tx !== 1'b0 || uart_tx_data !== 8'h11) $display("FAIL iso_no_start: start %b data %h want 0/11", uart_start_tx, uart_tx_data); else pass_cnt++;
        uart_tx_idle = 1'b0;
        #1;
        total_cnt++; if (req_tx_idle !== 4'b1101) $display("FAIL iso_idle_lo: got %b want 1101", req_tx_idle); else pass_cnt++;
        uart_tx_idle = 1'b1;
        #1;
        total_cnt++; if (req_tx_idle !== 4'b1111) $display("FAIL iso_idle_hi: got %b want 1111", req_tx_idle); else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (uart_start_tx !== 1'b0) seen = 1'b1;
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL iso_not_queued: start seen %b want 0", seen); else pass_cnt++;
    endtask

    task automatic test_drop_with_start();
        req_tx_data[15:8] = 8'h5A;
        req_start_tx = 4'b0010;
        req_run = 4'b0000;
        tick();
        req_start_tx = '0;
        total_cnt++; if (uart_start_tx !== 1'b1 || uart_tx_data !== 8'h5A) $display("FAIL drop_fwd: start %b data %h want 1/5a", uart_start_tx, uart_tx_data); else pass_cnt++;
        total_cnt++; if (grant !== 4'b0000 || busy !== 1'b1) $display("FAIL drop_grant: grant %b busy %b want 0000/1", grant, busy); else pass_cnt++;
        tick();
        uart_tx_idle = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total_cnt++; if (busy !== 1'b1) $display("FAIL drop_wait: busy %b want 1", busy); else pass_cnt++;
        uart_tx_idle = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        total_cnt++; if (busy !== 1'b1) $display("FAIL drop_gap_busy: busy %b want 1", busy); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL drop_gap_end: busy %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic early;
        req_run = 4'b0100;
        tick();
        total_cnt++; if (grant !== 4'b0100) $display("FAIL tmo_grant: got %b want 0100", grant); else pass_cnt++;
`ifdef UART_TX_ARB_TIMEOUT_EN
        early = 1'b0;
        for (int i = 1; i < 100; i++) begin
            tick();
            if (timeout_err !== 1'b0 || grant !== 4'b0100) early = 1'b1;
        end
        total_cnt++; if (early !== 1'b0) $display("FAIL tmo_early: early release %b want 0", early); else pass_cnt++;
        tick();
        total_cnt++; if (timeout_err !== 1'b1 || grant !== 4'b0000) $display("FAIL tmo_fire: err %b grant %b want 1/0000", timeout_err, grant); else pass_cnt++;
        tick();
        total_cnt++; if (timeout_err !== 1'b0) $display("FAIL tmo_pulse: err %b want 0", timeout_err); else pass_cnt++;
        wait_idle("tmo_a");
        tick(); tick(); tick();
        total_cnt++; if (grant !== 4'b0000) $display("FAIL tmo_masked: got %b want 0000", grant); else pass_cnt++;
        req_run = '0; tick();
        req_run = 4'b0100; tick();
        total_cnt++; if (grant !== 4'b0100) $display("FAIL tmo_regrant: got %b want 0100", grant); else pass_cnt++;
`else
        early = 1'b0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (timeout_err !== 1'b0 || grant !== 4'b0100) early = 1'b1;
        end
        total_cnt++; if (early !== 1'b0) $display("FAIL tmo_held: release or err seen %b want 0", early); else pass_cnt++;
`endif
        req_run = '0;
        tick();
        wait_idle("tmo_b");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        req_run = 4'b0001;
        tick();
        total_cnt++; if (grant !== 4'b0001) $display("FAIL mid_grant: got %b want 0001", grant); else pass_cnt++;
        for (int b = 0; b < 10; b++) begin
            d = 8'(8'h20 + b * 3);
            req_tx_data[7:0] = d;
            req_start_tx = 4'b0001;
            tick();
            req_start_tx = '0;
            uart_tx_idle = 1'b0;
            if (b < 9) begin
                tick(); tick();
                uart_tx_idle = 1'b1;
                tick();
            end
        end
        rst = 1'b1;
        tick();
        total_cnt++; if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL mid_rst_grant: grant %b busy %b want 0000/0", grant, busy); else pass_cnt++;
        total_cnt++; if (uart_tx_data !== 8'h00 || uart_start_tx !== 1'b0) $display("FAIL mid_rst_uart: data %h start %b want 00/0", uart_tx_data, uart_start_tx); else pass_cnt++;
        total_cnt++; if (req_tx_idle !== 4'b1111 || timeout_err !== 1'b0) $display("FAIL mid_rst_idle: idle %b err %b want 1111/0", req_tx_idle, timeout_err); else pass_cnt++;
        rst = 1'b0;
        uart_tx_idle = 1'b1;
        req_run = 4'b0011;
        tick();
        total_cnt++; if (grant !== 4'b0001) $display("FAIL mid_regrant: got %b want 0001", grant); else pass_cnt++;
        req_run = '0;
        tick();
        wait_idle("mid");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_nonowner_start();
        test_drop_with_start();
        test_timeout();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed so far", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
